// File: rtl/fmeas_sequencer.sv
// Measurement sequencer for ring-oscillator frequency counters: generates the
// counter clear and gate pulses, waits for the counters to settle, snapshots all
// channel counts, then streams one framed, parity-protected word per enabled
// channel on a single serial pin.
module fmeas_sequencer #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned COUNTER_LENGTH = 20,
  parameter int unsigned GATE_BASE      = 4,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter bit          ENCODE         = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ena,
  input  logic                             start_i,
  input  logic                             abort_i,
  input  logic                             cont_i,
  input  logic [1:0]                       gate_sel_i,
  input  logic [NUM_CH-1:0]                ch_mask_i,
  input  logic [NUM_CH*COUNTER_LENGTH-1:0] counts_i,
  output logic                             ctr_reset_o,
  output logic                             gate_o,
  output logic                             sdata_o,
  output logic                             sframe_o,
  output logic                             busy_o,
  output logic                             done_o
);

  localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned FRAME_W      = 4 + CH_W + COUNTER_LENGTH + 1;
  localparam int unsigned POS_W        = $clog2(FRAME_W);
  // Gate timer must hold 2^(GATE_BASE+3); settle timer must hold SETTLE_CYCLES.
  localparam int unsigned GATE_TMR_W   = GATE_BASE + 4;
  localparam int unsigned SETTLE_TMR_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TMR_W        = (GATE_TMR_W > SETTLE_TMR_W) ? GATE_TMR_W : SETTLE_TMR_W;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StGate,
    StSettle,
    StCapture,
    StShift,
    StDone
  } state_e;

  state_e                    r_state, w_state_d;
  logic [TMR_W-1:0]          r_timer, w_timer_d;
  logic [1:0]                r_gate_sel, w_gate_sel_d;
  logic [POS_W-1:0]          r_pos, w_pos_d;
  logic [CH_W-1:0]           r_ch, w_ch_d;
  logic [NUM_CH-1:0]         r_mask, w_mask_d;
  logic [COUNTER_LENGTH-1:0] r_counts [NUM_CH];
  logic                      r_bit, w_bit_d;
  logic                      w_capture;
  logic                      r_ctr_reset, r_gate, r_sframe, r_busy, r_done;

  logic [TMR_W-1:0]          w_gate_load;
  logic [POS_W-1:0]          w_pos_inc;
  logic [COUNTER_LENGTH-1:0] w_cur_count;
  logic [FRAME_W-1:0]        w_frame;
  logic [FRAME_W-1:0]        w_frame_rev;
  logic [CH_W-1:0]           w_first_ch;
  logic [CH_W-1:0]           w_nxt_ch;
  logic                      w_nxt_found;

  assign w_gate_load = (TMR_W'(1) << (GATE_BASE + 32'(r_gate_sel))) - TMR_W'(1);
  assign w_pos_inc   = r_pos + POS_W'(1);

  // Current frame and channel search helpers; frame bit i of w_frame_rev is the i-th bit sent.
  always_comb begin
    w_cur_count = r_counts[r_ch];
    w_frame     = {4'b1010, r_ch, w_cur_count, ^{r_ch, w_cur_count}};
    w_frame_rev = '0;
    for (int i = 0; i < int'(FRAME_W); i++) begin
      w_frame_rev[i] = w_frame[int'(FRAME_W) - 1 - i];
    end
    w_first_ch  = '0;
    w_nxt_ch    = '0;
    w_nxt_found = 1'b0;
    // Descending scans so the lowest qualifying index wins.
    for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
      if (ch_mask_i[k]) begin
        w_first_ch = CH_W'(k);
      end
      if (r_mask[k] && (k > int'(r_ch))) begin
        w_nxt_found = 1'b1;
        w_nxt_ch    = CH_W'(k);
      end
    end
  end

  // Next-state logic: sequencing timers, bit pointer and next raw serial bit.
  always_comb begin
    w_state_d    = r_state;
    w_timer_d    = r_timer;
    w_gate_sel_d = r_gate_sel;
    w_pos_d      = r_pos;
    w_ch_d       = r_ch;
    w_mask_d     = r_mask;
    w_bit_d      = 1'b0;
    w_capture    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start_i) begin
          w_state_d    = StClear;
          w_timer_d    = TMR_W'(1);
          w_gate_sel_d = gate_sel_i;
        end
      end
      StClear: begin
        if (r_timer == '0) begin
          w_state_d = StGate;
          w_timer_d = w_gate_load;
        end else begin
          w_timer_d = r_timer - TMR_W'(1);
        end
      end
      StGate: begin
        if (r_timer == '0) begin
          w_state_d = StSettle;
          w_timer_d = TMR_W'(SETTLE_CYCLES - 1);
        end else begin
          w_timer_d = r_timer - TMR_W'(1);
        end
      end
      StSettle: begin
        if (r_timer == '0) begin
          w_state_d = StCapture;
        end else begin
          w_timer_d = r_timer - TMR_W'(1);
        end
      end
      StCapture: begin
        w_capture = 1'b1;
        w_mask_d  = ch_mask_i;
        if (|ch_mask_i) begin
          w_state_d = StShift;
          w_pos_d   = '0;
          w_ch_d    = w_first_ch;
          w_bit_d   = 1'b1;  // every frame opens with the header MSB
        end else begin
          w_state_d = StDone;
        end
      end
      StShift: begin
        if (r_pos == POS_W'(FRAME_W - 1)) begin
          if (w_nxt_found) begin
            w_ch_d  = w_nxt_ch;
            w_pos_d = '0;
            w_bit_d = 1'b1;
          end else begin
            w_state_d = StDone;
          end
        end else begin
          w_pos_d = w_pos_inc;
          w_bit_d = w_frame_rev[w_pos_inc];
        end
      end
      StDone: begin
        if (cont_i) begin
          w_state_d = StClear;
          w_timer_d = TMR_W'(1);
        end else begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (abort_i) begin
      w_state_d = StIdle;
      w_bit_d   = 1'b0;
    end
  end

  // State, timers and registered outputs; everything holds while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_timer     <= '0;
      r_gate_sel  <= '0;
      r_pos       <= '0;
      r_ch        <= '0;
      r_mask      <= '0;
      r_bit       <= 1'b0;
      r_ctr_reset <= 1'b0;
      r_gate      <= 1'b0;
      r_sframe    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (ena) begin
      r_state     <= w_state_d;
      r_timer     <= w_timer_d;
      r_gate_sel  <= w_gate_sel_d;
      r_pos       <= w_pos_d;
      r_ch        <= w_ch_d;
      r_mask      <= w_mask_d;
      r_bit       <= w_bit_d;
      r_ctr_reset <= (w_state_d == StClear);
      r_gate      <= (w_state_d == StGate);
      r_sframe    <= (w_state_d == StShift);
      r_busy      <= (w_state_d != StIdle);
      r_done      <= (w_state_d == StDone);
    end
  end

  // Count snapshot taken once per measurement, in the capture cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NUM_CH); k++) begin
        r_counts[k] <= '0;
      end
    end else if (ena && w_capture) begin
      for (int k = 0; k < int'(NUM_CH); k++) begin
        r_counts[k] <= counts_i[k*COUNTER_LENGTH +: COUNTER_LENGTH];
      end
    end
  end

  assign ctr_reset_o = r_ctr_reset;
  assign gate_o      = r_gate;
  assign sframe_o    = r_sframe;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  // Clock-embedded line code: the raw bit is XORed with the running clock.
  assign sdata_o     = ENCODE ? (r_bit ^ clk) : r_bit;

endmodule

// File: tb/tb_fmeas_sequencer.sv
// Directed self-checking bench for fmeas_sequencer with default parameters.
`timescale 1ns / 1ps
module tb_fmeas_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        cont_i = 1'b0;
  logic [1:0]  gate_sel_i = 2'd0;
  logic [3:0]  ch_mask_i = 4'd0;
  logic [79:0] counts_i = '0;
  logic        ctr_reset_o, gate_o, sdata_o, sframe_o, busy_o, done_o;

  fmeas_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .cont_i      (cont_i),
    .gate_sel_i  (gate_sel_i),
    .ch_mask_i   (ch_mask_i),
    .counts_i    (counts_i),
    .ctr_reset_o (ctr_reset_o),
    .gate_o      (gate_o),
    .sdata_o     (sdata_o),
    .sframe_o    (sframe_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Results of one measurement run; cycle 1 is the first cycle after start is sampled.
  int          m_first_clr, m_cnt_clr, m_first_gate, m_cnt_gate, m_first_sf, m_nbits;
  int          m_done_cyc, m_cnt_done, m_freeze_err;
  logic        m_idle_after;
  logic [63:0] m_bits;

  task automatic measure(input logic [1:0] gsel, input logic [3:0] mask, input logic [79:0] cnts,
                         input int freeze_at);
    int   c;
    logic held;
    bit   stop;
    m_first_clr = -1; m_cnt_clr = 0; m_first_gate = -1; m_cnt_gate = 0; m_first_sf = -1;
    m_nbits = 0; m_done_cyc = -1; m_cnt_done = 0; m_freeze_err = 0; m_idle_after = 1'b0;
    m_bits = '0;
    gate_sel_i = gsel; ch_mask_i = mask; counts_i = cnts; start_i = 1'b1;
    c = 0; stop = 1'b0;
    while (!stop && c < 400) begin
      @(negedge clk);
      c++;
      start_i    = 1'b0;
      gate_sel_i = ~gsel;  // must have been latched with start
      if (ctr_reset_o) begin
        if (m_first_clr < 0) m_first_clr = c;
        m_cnt_clr++;
      end
      if (gate_o) begin
        if (m_first_gate < 0) m_first_gate = c;
        m_cnt_gate++;
      end
      if (sframe_o) begin
        if (m_first_sf < 0) m_first_sf = c;
        m_bits = {m_bits[62:0], sdata_o};
        m_nbits++;
        ch_mask_i = ~mask;  // post-capture input changes must be ignored
        counts_i  = ~cnts;
        if (m_nbits == freeze_at) begin
          held = sdata_o;
          ena  = 1'b0;
          for (int f = 0; f < 10; f++) begin
            @(posedge clk);
            #1;
            if (sdata_o !== ~held) m_freeze_err++;
            @(negedge clk);
            c++;
            if (sframe_o !== 1'b1 || sdata_o !== held || busy_o !== 1'b1) m_freeze_err++;
          end
          ena = 1'b1;
        end
      end
      if (done_o) begin
        m_cnt_done++;
        if (m_done_cyc < 0) m_done_cyc = c;
      end
      if (m_done_cyc >= 0 && c == m_done_cyc + 1) begin
        m_idle_after = !busy_o && !done_o && !sframe_o;
        stop = 1'b1;
      end
    end
  endtask

  logic [26:0] frame_a;
  logic [53:0] frame_b;
  int          c;
  int          done1, done2, gcnt;

  initial begin
    frame_a = {4'b1010, 2'b00, 20'h12345, 1'b1};
    frame_b = {4'b1010, 2'b01, 20'hFFFFF, 1'b1, 4'b1010, 2'b11, 20'h00000, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_val("reset_outs", {ctr_reset_o, gate_o, sframe_o, busy_o, done_o}, 5'b0);
    check_val("reset_sdata_low_clk", sdata_o, 1'b0);
    @(posedge clk);
    #1;
    check_val("reset_sdata_high_clk", sdata_o, 1'b1);
    @(negedge clk);

    // Asynchronous reset mid-GATE
    gate_sel_i = 2'd0; ch_mask_i = 4'b0001; start_i = 1'b1;
    for (c = 1; c <= 7; c++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    check_val("rst_pre_gate", gate_o, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_val("rst_async_outs", {ctr_reset_o, gate_o, sframe_o, busy_o, done_o}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_after_release", {ctr_reset_o, gate_o, sframe_o, busy_o, done_o}, 5'b0);

    // Single channel, G=16
    measure(2'd0, 4'b0001, {20'hAAAAA, 20'h55555, 20'h0F0F0, 20'h12345}, -1);
    check_val("a_first_clr", m_first_clr, 1);
    check_val("a_cnt_clr", m_cnt_clr, 2);
    check_val("a_first_gate", m_first_gate, 3);
    check_val("a_cnt_gate", m_cnt_gate, 16);
    check_val("a_first_sf", m_first_sf, 24);
    check_val("a_nbits", m_nbits, 27);
    check_val("a_bits", m_bits, 64'(frame_a));
    check_val("a_done_cyc", m_done_cyc, 51);
    check_val("a_cnt_done", m_cnt_done, 1);
    check_val("a_idle_after", m_idle_after, 1'b1);

    // Mask 1010: channels 1 and 3 only
    measure(2'd0, 4'b1010, {20'h00000, 20'h13579, 20'hFFFFF, 20'h2468A}, -1);
    check_val("b_first_sf", m_first_sf, 24);
    check_val("b_nbits", m_nbits, 54);
    check_val("b_bits", m_bits, 64'(frame_b));
    check_val("b_done_cyc", m_done_cyc, 78);

    // Longest gate, empty mask
    measure(2'd3, 4'b0000, {4{20'h11111}}, -1);
    check_val("c_first_gate", m_first_gate, 3);
    check_val("c_cnt_gate", m_cnt_gate, 128);
    check_val("c_nbits", m_nbits, 0);
    check_val("c_done_cyc", m_done_cyc, 136);
    check_val("c_cnt_done", m_cnt_done, 1);

    // Abort in gate cycle 5
    gate_sel_i = 2'd0; ch_mask_i = 4'b0001; start_i = 1'b1;
    for (c = 1; c <= 7; c++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    check_val("abort_pre_gate", gate_o, 1'b1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check_val("abort_gate_low", gate_o, 1'b0);
    check_val("abort_busy_low", busy_o, 1'b0);
    gcnt = 0;
    for (c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done_o || busy_o) gcnt++;
    end
    check_val("abort_no_done", gcnt, 0);
    start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0;
    check_val("abort_over_start", {busy_o, ctr_reset_o}, 2'b00);
    @(negedge clk);
    check_val("abort_stays_idle", busy_o, 1'b0);

    // Enable freeze for 10 cycles after the 10th frame bit
    measure(2'd0, 4'b0001, {20'hAAAAA, 20'h55555, 20'h0F0F0, 20'h12345}, 10);
    check_val("f_freeze_err", m_freeze_err, 0);
    check_val("f_nbits", m_nbits, 27);
    check_val("f_bits", m_bits, 64'(frame_a));
    check_val("f_done_cyc", m_done_cyc, 61);

    // Continuous mode: second clear right after done, same latched G=32
    cont_i = 1'b1; gate_sel_i = 2'd1; ch_mask_i = 4'b0000; start_i = 1'b1;
    done1 = -1; done2 = -1; gcnt = 0;
    for (c = 1; c <= 300 && done2 < 0; c++) begin
      @(negedge clk);
      start_i    = 1'b0;
      gate_sel_i = 2'd3;
      if (done1 >= 0 && gate_o) gcnt++;
      if (done_o) begin
        if (done1 < 0) begin
          done1 = c;
          @(negedge clk);
          c++;
          check_val("cont_clr_after_done", ctr_reset_o, 1'b1);
          cont_i = 1'b0;
        end else begin
          done2 = c;
        end
      end
    end
    check_val("cont_done1", done1, 40);
    check_val("cont_gate2_len", gcnt, 32);
    check_val("cont_done2", done2, 80);
    @(negedge clk);
    check_val("cont_idle_end", busy_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fmeas_sequencer.md
# fmeas_sequencer

Parametrised, single-clock measurement sequencer and serial readout for the ring-oscillator frequency counters. It generates the counter clear and gate pulses itself with a programmable gate length, waits a settle interval, and snapshots all channel counts at once. It then streams one framed, parity-protected word per enabled channel on a single output pin. It replaces manual gate/latch/select pin control, and it scales to any channel count and counter width.

## Interface
Parameters:
- NUM_CH, 4, number of counter channels (≥1); CH_W = max(1, clog2(NUM_CH))
- COUNTER_LENGTH, 20, width of each channel count
- GATE_BASE, 4, gate length G = 2^(GATE_BASE + gate_sel) clk cycles
- SETTLE_CYCLES, 4, idle cycles between gate fall and capture (≥1); covers oscillator-domain counter settling
- ENCODE, 1, 1: sdata_o = bit XOR clk (clock-embedded); 0: sdata_o = raw bit

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  global enable; low freezes all state and outputs
- start_i  in  1  level; starts a measurement when sampled high in IDLE
- abort_i  in  1  level; forces IDLE from any state
- cont_i  in  1  continuous mode; sampled in DONE
- gate_sel_i  in  2  gate length select, sampled in IDLE with start_i
- ch_mask_i  in  NUM_CH  channel enable mask, sampled in CAPTURE
- counts_i  in  NUM_CH*COUNTER_LENGTH  channel k at bits [k*CL +: CL]
- ctr_reset_o  out  1  counter clear to the measurement blocks
- gate_o  out  1  gate to the measurement blocks
- sdata_o  out  1  serial data (encoded per ENCODE)
- sframe_o  out  1  high while a valid data bit is on the line
- busy_o  out  1  state ≠ IDLE
- done_o  out  1  one-cycle pulse at end of sequence

## Operation
- States: IDLE, CLEAR, GATE, SETTLE, CAPTURE, SHIFT, DONE.
- IDLE: all outputs low. start_i=1 → CLEAR. gate_sel_i is latched on the same cycle.
- CLEAR: ctr_reset_o=1 for exactly 2 cycles → GATE.
- GATE: gate_o=1 for exactly G cycles → SETTLE.
- SETTLE: SETTLE_CYCLES cycles, all strobes low → CAPTURE.
- CAPTURE: 1 cycle. Snapshot counts_i and ch_mask_i into internal registers; later input changes have no effect. If the mask is all zero → DONE; otherwise → SHIFT.
- SHIFT: for each enabled channel, ascending index, emit a frame of F = 4+CH_W+COUNTER_LENGTH+1 bits, MSB first:
  - header 1010
  - channel index (CH_W bits)
  - count
  - parity bit
- Parity makes the ones-count over index+count+parity even. The header is excluded.
- Frames are back-to-back with no gap; sframe_o=1 throughout. After the last bit → DONE.
- DONE: done_o=1 for 1 cycle. cont_i=1 → CLEAR, reusing the latched gate_sel; otherwise → IDLE.
- abort_i=1 (and ena=1), any state: next state is IDLE, with all outputs low from the following cycle. No done_o. Abort takes priority over start_i.
- ena=0: FSM, timers, bit pointer and every registered output hold their values. The ENCODE XOR still follows clk.
- Reset: state IDLE; ctr_reset_o, gate_o, sframe_o, busy_o, done_o = 0. The raw data bit = 0, so sdata_o = 0 (ENCODE=0) or clk (ENCODE=1).

## Timing
- All outputs except the ENCODE XOR are registered and reflect the current state.
- start_i sampled high at edge t → ctr_reset_o high for cycles t+1..t+2 → gate_o high for cycles t+3..t+2+G.
- Capture occurs in cycle t+3+G+SETTLE_CYCLES; the first sframe_o bit is in the next cycle.
- Shift length is F × (enabled channels) cycles. done_o occurs in the cycle after the last bit.
- Continuous mode: ctr_reset_o rises in the cycle after done_o.
- Counters never wrap inside this block. The gate timer is wide enough for 2^(GATE_BASE+3).

## Test plan
- Reset: assert rst_n=0 mid-GATE, asynchronously → gate_o, ctr_reset_o, sframe_o, busy_o, done_o drop to 0 immediately and stay 0 after release with start_i=0.
- Single channel (defaults), gate_sel=0, mask=0001, counts ch0=20'h12345 → ctr_reset_o 2 cycles, gate_o 16 cycles, 4 settle cycles, then 27 bits 1010_00_0001_0010_0011_0100_0101_1, then done_o pulse.
- Mask=1010, ch1=20'hFFFFF, ch3=0 → 54 frame bits: 1010_01_FFFFF_1 then 1010_11_00000_0. Channels 0 and 2 are absent.
- gate_sel=3 → gate_o high exactly 128 cycles. Mask=0000 → done_o the cycle after CAPTURE, sframe_o never high.
- abort_i pulsed during GATE cycle 5 → gate_o low the next cycle, busy_o 0, no done_o. start_i asserted together with abort_i in IDLE → stays IDLE.
- ena=0 for 10 cycles mid-SHIFT → bit position, sframe_o and raw bit frozen, then resume with an identical stream. cont_i=1 → second ctr_reset_o rises the cycle after done_o, with the same G.
